gray_step_counter: RTL

- Single-clock up/down counter that produces a registered 4-bit (parameterisable) Gray code together with its binary equivalent.
- It sits directly upstream of the Gray-to-binary decoder and supplies it with a Gray sequence in which successive values differ in exactly one bit.
- The binary output is a golden reference, so downstream decode can be checked against it cycle by cycle.
- Supports parallel load, wrap or saturate at the ends, and end-of-range flags.

---
 rtl/gray_step_counter.sv | 71 +++++++
 1 files changed

// File: rtl/gray_step_counter.sv
// Up/down counter with a registered Gray-code output and a registered binary reference.
// Supports parallel load, wrap or saturate at the ends, and end-of-range flags.
module gray_step_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             sat_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             wrap_o,
  output logic             at_max_o,
  output logic             at_min_o
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      if (up_i) begin
        if (cnt_q != MAX) begin
          cnt_d = cnt_q + ONE;
        end else if (!sat_i) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (!sat_i) begin
          cnt_d  = MAX;
          wrap_d = 1'b1;
        end
      end
    end
    // Gray is encoded from the next count so it is registered alongside it, never decoded from bin.
    gray_d = cnt_d ^ (cnt_d >> 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_o    = cnt_q;
  assign gray_o   = gray_q;
  assign wrap_o   = wrap_q;
  assign at_max_o = (cnt_q == MAX);
  assign at_min_o = (cnt_q == '0);

endmodule
